// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA gradient control path: FSM encoding,
// window border radius and the default counter width.
package cfa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned WIN_R         = 2;
  localparam int unsigned CNT_W_DEFAULT = 12;

endpackage

// File: rtl/gradients_tag_pipe.sv
// GRAD_LAT-deep shift register of {valid, row, col} tags that tracks the
// gradient datapath; advances only when en is high, async active-low clear.
module gradients_tag_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_row,
  input  logic [CNT_W-1:0] in_col,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic             any_valid
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] row_q [DEPTH];
  logic [CNT_W-1:0] row_d [DEPTH];
  logic [CNT_W-1:0] col_q [DEPTH];
  logic [CNT_W-1:0] col_d [DEPTH];

  always_comb begin
    valid_d = valid_q;
    row_d   = row_q;
    col_d   = col_q;
    if (en) begin
      valid_d[0] = in_valid;
      row_d[0]   = in_row;
      col_d[0]   = in_col;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        row_d[i]   = row_q[i-1];
        col_d[i]   = col_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_row   = row_q[DEPTH-1];
  assign out_col   = col_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/gradients_ctrl.sv
// Raster-scan sequencer for the CFA gradient datapath with result tagging.
// Define GRAD_STALL_CNT_EN to add the per-frame stall_cnt output.
module gradients_ctrl
  import cfa_pkg::*;
#(
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 48,
  parameter int unsigned GRAD_LAT = 2,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic [CNT_W-1:0] lb_addr,
  output logic             win_shift,
  output logic             grad_en,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic             busy,
  output logic             done
`ifdef GRAD_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] EDGE     = CNT_W'(2 * WIN_R);
  localparam logic [CNT_W-1:0] BORDER   = CNT_W'(WIN_R);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             adv;
  logic             accept;
  logic             tag_valid;
  logic             pipe_any;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    in_ready = 1'b0;
    done     = 1'b0;
    adv      = !out_valid || out_ready;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        in_ready = adv;
        if (in_valid && adv) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == LAST_ROW) state_d = DRAIN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // pipe_any covers the output stage, so this also implies out_valid=0
        if (!pipe_any) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    accept    = in_valid && in_ready;
    tag_valid = accept && (row_q >= EDGE) && (col_q >= EDGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  gradients_tag_pipe #(
    .DEPTH (GRAD_LAT),
    .CNT_W (CNT_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst),
    .en        (adv),
    .in_valid  (tag_valid),
    .in_row    (row_q - BORDER),
    .in_col    (col_q - BORDER),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .any_valid (pipe_any)
  );

  assign grad_en   = adv;
  assign win_shift = accept;
  assign lb_addr   = col_q;
  assign busy      = (state_q != IDLE);

`ifdef GRAD_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_gradients_ctrl.sv
// Bench for gradients_ctrl on an 8x6 frame; honours GRAD_STALL_CNT_EN.
module tb_gradients_ctrl;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int LAT = 2;
  localparam int CW  = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic [CW-1:0] lb_addr;
  logic          win_shift;
  logic          grad_en;
  logic          out_valid;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          done;
`ifdef GRAD_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  gradients_ctrl #(
    .IMG_W    (W),
    .IMG_H    (H),
    .GRAD_LAT (LAT),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .lb_addr   (lb_addr),
    .win_shift (win_shift),
    .grad_en   (grad_en),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
`ifdef GRAD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame position as a pixel index, and the list of
  // pending centres each aged in datapath-enabled cycles.
  typedef struct {
    int row;
    int col;
    int age;
  } item_t;

  item_t q[$];
  int    m_state;    // 0 idle, 1 run, 2 drain
  int    m_pix;
  int    m_results;
  int    m_stalls;

  task automatic check_all_zero(input string ph);
    check({ph, "_out_valid"}, out_valid, 0);
    check({ph, "_out_row"},   out_row,   0);
    check({ph, "_out_col"},   out_col,   0);
    check({ph, "_lb_addr"},   lb_addr,   0);
    check({ph, "_in_ready"},  in_ready,  0);
    check({ph, "_win_shift"}, win_shift, 0);
    check({ph, "_busy"},      busy,      0);
    check({ph, "_done"},      done,      0);
  endtask

  task automatic run_frame(input int vmode, input int rmode, input bit spam, input int abort_pix);
    int  stall_left = 5;
    bit  fin = 0;
    bit  aborted = 0;
    int  cyc_acc44 = -1;
    int  cyc_first = -1;
    int  cyc_last = -1;
    bit  head_ov, exp_ov, exp_adv, exp_ir, acc, exp_done;
    int  r, c;
    item_t it;
    q.delete();
    m_results = 0;
    m_stalls  = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      head_ov = (q.size() > 0) && (q[0].age == LAT);
      start = (cyc == 0) || (spam && (cyc == 12 || m_state == 2));
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(0, 1) == 1);
      endcase
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          if (m_results >= 3 && head_ov && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase

      @(negedge clk);
      exp_ov   = (q.size() > 0) && (q[0].age == LAT);
      exp_adv  = !exp_ov || out_ready;
      exp_ir   = (m_state == 1) && exp_adv;
      acc      = exp_ir && in_valid;
      exp_done = (m_state == 2) && (q.size() == 0);

      check("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        check("out_row", out_row, q[0].row);
        check("out_col", out_col, q[0].col);
      end
      check("in_ready",  in_ready,  exp_ir);
      check("grad_en",   grad_en,   exp_adv);
      check("win_shift", win_shift, acc);
      check("busy",      busy,      m_state != 0);
      check("done",      done,      exp_done);
      if (m_state == 1) check("lb_addr", lb_addr, m_pix % W);

      if (exp_ov && out_ready) begin
        m_results++;
        if (cyc_first < 0) cyc_first = cyc;
        cyc_last = cyc;
      end
      if (exp_ov && !out_ready) m_stalls++;
      if (exp_done) begin
        check("done_after_last", cyc - cyc_last, 1);
        m_state = 0;
        fin = 1;
      end
      if (exp_adv) begin
        if (exp_ov) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
      end
      if (acc) begin
        r = m_pix / W;
        c = m_pix % W;
        if (m_pix == 4 * W + 4) cyc_acc44 = cyc;
        if (r >= 4 && c >= 4) begin
          it.row = r - 2;
          it.col = c - 2;
          it.age = 1;
          q.push_back(it);
        end
        if (m_pix == W * H - 1) m_state = 2;
        m_pix++;
      end
      if (m_state == 0 && start && !fin) begin
        m_state = 1;
        m_pix   = 0;
      end

      if (abort_pix >= 0 && m_state == 1 && m_pix == abort_pix) begin
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("abort");
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst     = 1'b1;
        m_state = 0;
        q.delete();
        aborted = 1;
        break;
      end

      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!aborted) begin
      if (!fin) check("frame_timeout", 0, 1);
      check("result_count", m_results, (W - 4) * (H - 4));
      if (vmode == 0 && rmode == 0) check("first_latency", cyc_first - cyc_acc44, LAT);
`ifdef GRAD_STALL_CNT_EN
      check("stall_cnt", stall_cnt, (rmode == 1) ? 5 : m_stalls);
`endif
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    m_state   = 0;
    m_pix     = 0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_in_ready",  in_ready,  0);
      check("idle_win_shift", win_shift, 0);
      check("idle_busy",      busy,      0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    run_frame(0, 0, 0, -1);
    run_frame(0, 1, 0, -1);
    run_frame(1, 0, 0, -1);
    run_frame(0, 0, 0, 3 * W + 2);
    run_frame(0, 0, 0, -1);
    run_frame(0, 0, 1, -1);
    for (int i = 0; i < 3; i++) run_frame(2, 2, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gradients_ctrl.md
# gradients_ctrl

Raster-scan sequencer for the CFA gradient datapath. It accepts a Bayer pixel stream over a valid/ready handshake and drives the line-buffer column address and the 5x5 window shift. It enables the gradient pipeline and tags each result with its centre coordinate and a valid aligned to the datapath latency. Downstream backpressure stalls the whole datapath. The block sits between the pixel input interface and the gradients/equ_4_5 datapath.

## Interface
- IMG_W, 64, frame width in pixels (>= 5)
- IMG_H, 48, frame height in pixels (>= 5)
- GRAD_LAT, 2, gradient datapath latency in enabled cycles (>= 1)
- CNT_W, 12, row/column counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- in_valid  in  1  input pixel present
- in_ready  out  1  controller accepts pixel this cycle
- out_ready  in  1  downstream accepts result
- lb_addr  out  CNT_W  line-buffer column address (= input column)
- win_shift  out  1  shift 5x5 window / write line buffers (= accept)
- grad_en  out  1  advance gradient datapath pipeline
- out_valid  out  1  gradient outputs valid for centre below
- out_row, out_col  out  CNT_W  centre coordinate of current result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last result handed off

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. start=1 clears row/col and moves to RUN. in_valid is ignored.
- adv = !out_valid | out_ready. grad_en = adv. Tag pipeline shifts only when adv=1.
- RUN: in_ready = adv.
  - accept = in_valid & in_ready. win_shift = accept. lb_addr = col.
  - On accept, col increments. At col = IMG_W-1 it wraps to 0 and row increments.
- Tag stage 0 input: valid = accept & row >= 4 & col >= 4, with centre (row-2, col-2). Only interior centres (2..IMG_H-3, 2..IMG_W-3) are produced.
- Transitions:
  - Accept of pixel (IMG_H-1, IMG_W-1) goes to DRAIN.
  - DRAIN: in_ready=0, win_shift=0. grad_en = adv so the pipeline flushes.
  - When no tag stage holds a valid and out_valid=0, done pulses and the state returns to IDLE.
- Results per frame: exactly (IMG_W-4)*(IMG_H-4).
- start while busy is ignored.
- Holding: out_valid=1 with out_ready=0 holds out_valid, out_row and out_col stable, and drops grad_en and in_ready.

## Timing
- Reset values: all state returns to IDLE, and every output is 0 (in_ready, win_shift, grad_en's registered dependants, out_valid, out_row, out_col, lb_addr, busy, done).
- Async assertion mid-frame aborts immediately; there is no done pulse.
- Latency: a qualifying accept at cycle t gives out_valid at t+GRAD_LAT, provided adv=1 throughout. Each adv=0 cycle adds one cycle.
- Ready path: in_ready combinationally depends on out_ready; there is no combinational path from in_valid.
- Full-rate case: with out_ready held at 1, one pixel is accepted per cycle with no bubbles.
- Simultaneous events:
  - An accept of the last pixel and a handoff in the same cycle are both honoured.
  - done asserts in the cycle after the final out_valid & out_ready.

## Configuration
- GRAD_STALL_CNT_EN defined:
  - Adds output stall_cnt [15:0], counting cycles with out_valid & !out_ready in the current frame.
  - Saturates at 16'hFFFF and clears on start.
- Undefined: no stall_cnt port and no counter logic.

## Structure
- Shared package cfa_pkg holds:
  - the state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - the window border constant WIN_R=2;
  - the CNT_W default.
- One sub-module, gradients_tag_pipe: a GRAD_LAT-deep shift register of {valid, row, col} with a shift enable and async active-low clear.

## Test plan
- IMG_W=8, IMG_H=6, GRAD_LAT=2, in_valid=1 and out_ready=1 constant, start pulse:
  - expect exactly 8 out_valid pulses with centres (2,2),(2,3),(2,4),(2,5),(3,2)..(3,5);
  - first out_valid 2 cycles after accept of pixel (4,4);
  - done 1 cycle after last result.
- Same stimulus, out_ready=0 for 5 cycles while out_valid=1:
  - coordinates hold, in_ready=0 and grad_en=0 throughout;
  - transfer resumes with no loss or duplicate (8 results total);
  - stall_cnt=5 with GRAD_STALL_CNT_EN.
- in_valid toggling 1010…: accepts occur only on in_valid=1 cycles, col wraps at 7, result count stays 8.
- rst low in RUN at row 3: all outputs 0 in the same cycle, state IDLE, no done; a fresh start gives a complete 8-result frame.
- start pulsed during RUN and DRAIN: ignored, frame completes normally; in_valid=1 while IDLE: in_ready stays 0.
- Drain ordering: accept of the last pixel (5,7) with out_ready=1 gives state DRAIN, and done pulses after final centre (3,5) is handed off.
